zhegalkin_anf_extract: RTL and testbench

- Inverse of the team's Zhegalkin evaluators: takes a Boolean function's truth table and computes its Zhegalkin (ANF) coefficient vector.
- Uses an iterative binary Möbius transform, one butterfly stage per clock.
- Also reports monomial count and algebraic degree.
- Feeds ANF coefficients to evaluator generation and checks hand-derived polynomials against truth tables.

---
 rtl/zhegalkin_anf_extract.sv | 107 ++++++++++
 tb/tb_zhegalkin_anf_extract.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/zhegalkin_anf_extract.sv
// Truth table to Zhegalkin (ANF) coefficients via an iterative binary Moebius transform,
// one butterfly stage per clock, followed by a registered monomial count and degree.
module zhegalkin_anf_extract #(
  parameter int NVAR = 4,
  localparam int TW = 2 ** NVAR,
  localparam int DW = $clog2(NVAR + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TW-1:0]   tt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TW-1:0]   anf,
  output logic [NVAR:0]   mono_cnt,
  output logic [DW-1:0]   degree
);

  // state  | meaning
  // IDLE   | waiting for a truth table
  // XFORM  | one butterfly stage per cycle
  // STATS  | register anf, monomial count and degree
  // DONE   | result held until out_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFORM = 2'd1;
  localparam logic [1:0] S_STATS = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [2:0]    stage;
  logic [TW-1:0] work;
  logic [TW-1:0] work_next;
  logic [NVAR:0] mono_next;
  logic [DW-1:0] degree_next;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Stage k folds every lower-half element into its partner with bit k set.
  always_comb begin
    work_next = work;
    for (int k = 0; k < NVAR; k++) begin
      if (stage == 3'(k)) begin
        for (int i = 0; i < TW; i++) begin
          if (((i >> k) & 1) == 1)
            work_next[NVAR'(i)] = work[NVAR'(i)] ^ work[NVAR'(i ^ (1 << k))];
        end
      end
    end
  end

  always_comb begin
    int cnt;
    int deg;
    cnt = 0;
    deg = 0;
    for (int i = 0; i < TW; i++) begin
      if (work[NVAR'(i)]) begin
        cnt = cnt + 1;
        if ($countones(NVAR'(i)) > deg)
          deg = $countones(NVAR'(i));
      end
    end
    mono_next   = (NVAR + 1)'(cnt);
    degree_next = DW'(deg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      stage    <= '0;
      work     <= '0;
      anf      <= '0;
      mono_cnt <= '0;
      degree   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= tt;
            stage <= '0;
            state <= S_XFORM;
          end
        end
        S_XFORM: begin
          work  <= work_next;
          stage <= stage + 3'd1;
          if (stage == 3'(NVAR - 1))
            state <= S_STATS;
        end
        S_STATS: begin
          anf      <= work;
          mono_cnt <= mono_next;
          degree   <= degree_next;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zhegalkin_anf_extract.sv
// Bench for zhegalkin_anf_extract: directed vectors, stall/reset cases and random
// tables checked against a subset-sum ANF model plus the involution property.
module tb_zhegalkin_anf_extract;
  localparam int NVAR = 4;
  localparam int TW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] tt;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] anf;
  logic [NVAR:0] mono_cnt;
  logic [2:0]    degree;

  int n_cmp = 0;
  int n_err = 0;

  zhegalkin_anf_extract #(.NVAR(NVAR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tt(tt),
    .out_valid(out_valid), .out_ready(out_ready), .anf(anf),
    .mono_cnt(mono_cnt), .degree(degree)
  );

  always #5 clk = ~clk;

  // Coefficient of monomial m is the XOR of f over all inputs that are subsets of m.
  function automatic logic [TW-1:0] model_anf(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    r = '0;
    for (int m = 0; m < TW; m++)
      for (int i = 0; i < TW; i++)
        if ((i & ~m) == 0) r[m] = r[m] ^ t[i];
    return r;
  endfunction

  function automatic int model_deg(input logic [TW-1:0] a);
    int d;
    d = 0;
    for (int m = 0; m < TW; m++)
      if (a[m] && $countones(m) > d) d = $countones(m);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present t, wait for out_valid (bounded), return latency in cycles; out_ready left as set by caller.
  task automatic launch(input logic [TW-1:0] t, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    tt = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tt = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic run_check(input string tag, input logic [TW-1:0] t, output logic [TW-1:0] got);
    int lat;
    logic [TW-1:0] e;
    out_ready = 1'b1;
    launch(t, lat);
    e = model_anf(t);
    chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    chk({tag, "_anf"}, 32'(anf), 32'(e));
    chk({tag, "_mono"}, 32'(mono_cnt), 32'($countones(e)));
    chk({tag, "_deg"}, 32'(degree), 32'(model_deg(e)));
    got = anf;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [TW-1:0] a, back, held, t;
    logic [NVAR:0] held_cnt;
    logic [2:0] held_deg;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_anf", 32'(anf), 32'd0);
    chk("rst_mono", 32'(mono_cnt), 32'd0);
    chk("rst_deg", 32'(degree), 32'd0);

    // Directed vectors with hand-derived results.
    out_ready = 1'b1;
    launch(16'h0AC5, lat);
    chk("lat_0ac5", 32'(lat), 32'd6);
    chk("anf_0ac5", 32'(anf), 32'h5173);
    chk("mono_0ac5", 32'(mono_cnt), 32'd8);
    chk("deg_0ac5", 32'(degree), 32'd3);
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
    chk("post_hs_anf_kept", 32'(anf), 32'h5173);

    launch(16'hFFFF, lat);
    chk("anf_ffff", 32'(anf), 32'h0001);
    chk("mono_ffff", 32'(mono_cnt), 32'd1);
    chk("deg_ffff", 32'(degree), 32'd0);
    @(negedge clk);
    launch(16'h0000, lat);
    chk("anf_0000", 32'(anf), 32'h0000);
    chk("mono_0000", 32'(mono_cnt), 32'd0);
    chk("deg_0000", 32'(degree), 32'd0);
    @(negedge clk);
    launch(16'h6996, lat);
    chk("anf_6996", 32'(anf), 32'h0116);
    chk("mono_6996", 32'(mono_cnt), 32'd4);
    chk("deg_6996", 32'(degree), 32'd1);
    @(negedge clk);
    launch(16'h8000, lat);
    chk("anf_8000", 32'(anf), 32'h8000);
    chk("mono_8000", 32'(mono_cnt), 32'd1);
    chk("deg_8000", 32'(degree), 32'd4);
    @(negedge clk);

    // Stall: outputs held, input ignored while busy.
    out_ready = 1'b0;
    launch(16'h1234, lat);
    chk("stall_valid", 32'(out_valid), 32'd1);
    held = anf; held_cnt = mono_cnt; held_deg = degree;
    chk("stall_anf_model", 32'(held), 32'(model_anf(16'h1234)));
    in_valid = 1'b1; tt = 16'hBEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_anf", 32'(anf), 32'(held));
      chk("stall_hold_mono", 32'(mono_cnt), 32'(held_cnt));
      chk("stall_hold_deg", 32'(degree), 32'(held_deg));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(out_valid), 32'd0);
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("stall_no_ghost", 32'(out_valid), 32'd0);

    // Reset mid-transform discards the in-flight table.
    launch(16'hC3A5, lat);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; tt = 16'h00F0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_anf", 32'(anf), 32'd0);
    chk("midrst_mono", 32'(mono_cnt), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random tables plus round trip: transforming the ANF must give back the table.
    for (int n = 0; n < 150; n++) begin
      t = 16'($urandom);
      run_check("rand", t, a);
      run_check("inv", a, back);
      chk("involution", 32'(back), 32'(t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
